// File: rtl/squarer_seq.sv
// Sequential unsigned squarer: P_o = R_i * R_i by shift-and-add, one bit of the
// operand per clock, fixed latency of WIDTH cycles from the accepting edge.
//
// state | meaning
// IDLE  | waiting for start_i; P_o holds the last result
// CALC  | one shift-and-add iteration per clock, WIDTH iterations in total
// DONE  | one-cycle result strobe, then back to IDLE
module squarer_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     R_i,
    output logic                 busy_o,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   P_o
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           state;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   acc_next;
    logic [CW-1:0]        cnt;

    // Partial product for the current multiplier bit, aligned by the iteration count.
    assign addend   = mplier[0] ? ({{WIDTH{1'b0}}, mcand} << cnt) : '0;
    assign acc_next = acc + addend;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= S_IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            P_o    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        mcand  <= R_i;
                        mplier <= R_i;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= S_CALC;
                    end
                end
                S_CALC: begin
                    acc    <= acc_next;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    // Last iteration: the sum just formed is the final square.
                    if (cnt == CW'(WIDTH - 1)) begin
                        P_o   <= acc_next;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state == S_CALC) || (state == S_DONE);
    assign done_o = (state == S_DONE);

endmodule

// File: tb/tb_squarer_seq.sv
// Randomized and directed bench for squarer_seq; a cycle-level latency model
// predicts busy/done/P every cycle, directed ops check values and timing.
module tb_squarer_seq;

    localparam int WIDTH = 8;

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic                 start_i;
    logic [WIDTH-1:0]     R_i;
    logic                 busy_o;
    logic                 done_o;
    logic [2*WIDTH-1:0]   P_o;

    squarer_seq #(.WIDTH(WIDTH)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .R_i     (R_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .P_o     (P_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: an accepted operand yields its square WIDTH edges later,
    // followed by one done cycle; reset wipes everything.
    bit          m_active = 1'b0;
    bit          m_done   = 1'b0;
    int          m_left   = 0;
    logic [31:0] m_res    = '0;
    logic [31:0] m_p      = '0;
    int          cyc      = 0;
    int          done_cnt = 0;
    bit          chk_en   = 1'b0;

    always @(posedge clk_i) begin
        cyc++;
        if (rst_i) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_p      = '0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_active) begin
            m_left--;
            if (m_left == 0) begin
                m_active = 1'b0;
                m_done   = 1'b1;
                m_p      = m_res;
            end
        end else if (start_i) begin
            m_active = 1'b1;
            m_left   = WIDTH;
            m_res    = 32'(R_i) * 32'(R_i);
        end
    end

    always @(negedge clk_i) begin
        if (chk_en) begin
            check("mon_busy", 32'(busy_o), 32'(m_active || m_done));
            check("mon_done", 32'(done_o), 32'(m_done));
            check("mon_p", 32'(P_o), m_p);
        end
        if (done_o) done_cnt++;
    end

    int done_cyc = 0;

    // Called at a negedge in IDLE; returns at the negedge of the done cycle.
    task automatic run_op(input logic [WIDTH-1:0] r, input logic [31:0] exp_p,
                          input int inject_at, input bit noise);
        int lat;
        start_i = 1'b1;
        R_i     = r;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        if (noise) R_i = WIDTH'($urandom);
        lat = 0;
        while (!done_o && lat < WIDTH + 4) begin
            @(posedge clk_i);
            @(negedge clk_i);
            lat++;
            if (!done_o) begin
                start_i = (lat == inject_at) || (noise && $urandom_range(3) == 0);
                if (lat == inject_at) R_i = WIDTH'(3);
                else if (noise) R_i = WIDTH'($urandom);
            end
        end
        start_i = 1'b0;
        check("done_seen", 32'(done_o), 32'd1);
        check("latency", 32'(lat), 32'(WIDTH));
        check("result", 32'(P_o), exp_p);
        done_cyc = cyc;
    endtask

    int d0;
    int c1;

    initial begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        R_i     = '0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_p", 32'(P_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        chk_en = 1'b1;

        run_op(8'd0, 32'h0000, 0, 1'b0);
        @(negedge clk_i);
        run_op(8'd13, 32'd169, 0, 1'b0);
        @(negedge clk_i);
        run_op(8'd255, 32'd65025, 0, 1'b0);
        @(negedge clk_i);
        run_op(8'd128, 32'h4000, 0, 1'b0);
        @(negedge clk_i);

        // Second start during CALC must be ignored.
        d0 = done_cnt;
        run_op(8'd200, 32'd40000, 3, 1'b0);
        repeat (4) @(negedge clk_i);
        check("single_done", 32'(done_cnt - d0), 32'd1);

        // Reset on the 4th CALC cycle aborts the operation.
        start_i = 1'b1;
        R_i     = 8'd255;
        @(posedge clk_i);
        @(negedge clk_i);
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        d0 = done_cnt;
        rst_i = 1'b1;
        @(negedge clk_i);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        check("abort_p", 32'(P_o), 32'd0);
        rst_i = 1'b0;
        run_op(8'd7, 32'd49, 0, 1'b0);
        repeat (3) @(negedge clk_i);
        check("abort_no_done", 32'(done_cnt - d0), 32'd1);

        // Back-to-back issue at the minimum interval.
        run_op(8'd15, 32'd225, 0, 1'b0);
        c1 = done_cyc;
        @(negedge clk_i);
        run_op(8'd16, 32'd256, 0, 1'b0);
        check("b2b_spacing", 32'(done_cyc - c1), 32'd10);
        @(negedge clk_i);

        for (int r = 0; r < 256; r++) begin
            run_op(WIDTH'(r), 32'(r * r), 0, 1'b1);
            repeat (1 + $urandom_range(2)) @(negedge clk_i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/squarer_seq.md
SQUARER_SEQ -- requirements
Module: squarer_seq

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, as the operand width in bits; legal range 2..16.
REQ-002 SHALL provide clk_i, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL provide rst_i, input, 1, synchronous active-high reset, sampled on the rising edge of clk_i.
REQ-004 SHALL provide start_i, input, 1, a request to square R_i; honoured only in IDLE.
REQ-005 SHALL provide R_i, input, WIDTH, unsigned operand (candidate root), sampled on the accepting edge.
REQ-006 SHALL provide busy_o, output, 1, high while an operation is in progress (states CALC and DONE).
REQ-007 SHALL provide done_o, output, 1, single-cycle pulse marking P_o valid for the new result.
REQ-008 SHALL provide P_o, output, 2*WIDTH, unsigned R_i*R_i, registered, holding the last result.

Function
REQ-009 SHALL implement an FSM with states IDLE, CALC and DONE, encoded in registers.
REQ-010 SHALL, in IDLE with start_i=1, perform these steps on that edge:
  - latch R_i into the multiplicand and multiplier registers
  - clear the 2*WIDTH accumulator and the iteration counter
  - move to CALC
REQ-011 SHALL, in IDLE with start_i=0, remain in IDLE with all registers unchanged.
REQ-012 SHALL, in CALC, perform one shift-and-add iteration per clock:
  - if the multiplier LSB is 1, add the multiplicand shifted left by the counter value to the accumulator
  - shift the multiplier right by 1
  - increment the counter
REQ-013 SHALL perform all additions unsigned at 2*WIDTH bits; the final result cannot overflow, since (2^WIDTH-1)^2 < 2^(2*WIDTH).
REQ-014 SHALL, on the edge completing iteration WIDTH, perform these steps:
  - load the final accumulator value into P_o
  - move to DONE
REQ-015 SHALL, in DONE, return to IDLE on the next edge unconditionally.
REQ-016 SHALL drive done_o=1 exactly while in DONE (one cycle per operation), and 0 otherwise.
REQ-017 SHALL give a fixed latency: if start_i is accepted on edge N, then done_o=1 and P_o is valid in the cycle following edge N+WIDTH.
REQ-018 SHALL drive busy_o=1 from the cycle after the accepting edge through the DONE cycle inclusive; busy_o is 0 in IDLE.
REQ-019 SHALL ignore start_i while in CALC or DONE, with no queuing and no effect on the running operation.
REQ-020 SHALL accept a new start_i on the first IDLE cycle after DONE, giving a minimum issue interval of WIDTH+2 cycles.
REQ-021 SHALL hold P_o stable between done_o pulses; P_o changes only on the REQ-014 edge or on reset.
REQ-022 SHALL ignore changes on R_i after the accepting edge; only the latched value is used.

Reset
REQ-023 SHALL, when rst_i=1 on an edge, set state=IDLE and clear the counter, accumulator, multiplicand and multiplier registers, and P_o to 0; busy_o=0 and done_o=0.
REQ-024 SHALL give rst_i priority over start_i and over any in-progress operation; an aborted operation never produces done_o.
REQ-025 SHALL accept start_i on the first edge with rst_i=0.

Verification
REQ-026 The bench SHALL apply rst_i for 2 cycles and then check P_o=0, busy_o=0 and done_o=0.
REQ-027 The bench SHALL run the following directed scenarios with WIDTH=8:
  - R_i=0 -> P_o=0x0000, done_o after exactly 8 cycles
  - R_i=13 -> P_o=169 (0x00A9)
  - R_i=255 -> P_o=65025 (0xFE01)
  - R_i=128 -> P_o=0x4000
REQ-028 The bench SHALL start with R_i=200, then pulse start_i with R_i=3 during CALC; the required response is P_o=40000 (0x9C40), exactly one done_o, and the second start ignored.
REQ-029 The bench SHALL start with R_i=255 and assert rst_i on the 4th CALC cycle; the required response is no done_o, P_o=0, and state IDLE; a following start with R_i=7 yields P_o=49.
REQ-030 The bench SHALL issue back-to-back starts with R_i=15 then R_i=16, the second on the first IDLE cycle after DONE; the required response is P_o=225 then P_o=256, with done pulses 10 cycles apart.
REQ-031 The bench SHALL run an exhaustive sweep of R_i=0..255 and check P_o against a reference square, busy_o/done_o timing per REQ-016 to REQ-018, and P_o stability between pulses.
